// File: rtl/pwm11_capture_if.sv
// Signal bundle between a PWM source and the pwm11_capture measurement block.
// The source side (master) drives the raw waveform and observes the results;
// the capture block (slave) consumes the waveform and produces the results.
interface pwm11_capture_if;
  logic        PWM_in;
  logic [10:0] duty;
  logic [11:0] period;
  logic        vld;
  logic        stuck;
  logic        level;

  modport master (
    output PWM_in,
    input  duty,
    input  period,
    input  vld,
    input  stuck,
    input  level
  );

  modport slave (
    input  PWM_in,
    output duty,
    output period,
    output vld,
    output stuck,
    output level
  );
endinterface

// File: rtl/pwm11_capture.sv
// PWM capture: synchronizes an asynchronous PWM waveform, measures high time
// and period between consecutive rising edges, and flags a stuck input when
// no rising edge arrives within TMO cycles.
module pwm11_capture #(
  parameter int TMO = 4095
) (
  input  logic           clk,
  input  logic           rst,
  pwm11_capture_if.slave cap
);

  localparam logic [11:0] TMO_C    = 12'(TMO);
  localparam logic [11:0] CNT_MAX  = 12'hFFF;
  localparam logic [10:0] DUTY_MAX = 11'h7FF;

  typedef enum logic [1:0] {
    IDLE,
    MEAS,
    STUCK
  } state_t;

  state_t      state_q;
  logic        s1_q;
  logic        s2_q;
  logic        prev_q;
  logic [11:0] per_cnt_q;
  logic [11:0] hi_cnt_q;
  logic [11:0] per_cnt_d;
  logic [11:0] hi_cnt_d;
  logic [10:0] duty_q;
  logic [11:0] period_q;
  logic        vld_q;
  logic        stuck_q;

  logic        rise;
  logic        timeout;
  logic [10:0] hi_sat;

  // Edge detect, timeout compare and saturating counter increments.
  always_comb begin
    rise      = s2_q & ~prev_q;
    timeout   = (per_cnt_q == TMO_C);
    per_cnt_d = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + 12'd1;
    hi_cnt_d  = (s2_q && (hi_cnt_q != CNT_MAX)) ? hi_cnt_q + 12'd1 : hi_cnt_q;
    hi_sat    = (hi_cnt_q > 12'd2047) ? DUTY_MAX : hi_cnt_q[10:0];
  end

  // Two-flop synchronizer plus a delay flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= cap.PWM_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  // Measurement FSM; a rise always beats a coincident timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      duty_q    <= '0;
      period_q  <= '0;
      vld_q     <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        IDLE, MEAS: begin
          if (rise) begin
            if (state_q == MEAS) begin
              duty_q   <= hi_sat;
              period_q <= per_cnt_q;
              vld_q    <= 1'b1;
            end
            per_cnt_q <= 12'd1;
            hi_cnt_q  <= 12'd1;
            state_q   <= MEAS;
          end else if (timeout) begin
            state_q  <= STUCK;
            stuck_q  <= 1'b1;
            vld_q    <= 1'b1;
            duty_q   <= s2_q ? DUTY_MAX : 11'd0;
            period_q <= 12'd0;
          end else begin
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
          end
        end
        STUCK: begin
          if (rise) begin
            state_q   <= MEAS;
            stuck_q   <= 1'b0;
            per_cnt_q <= 12'd1;
            hi_cnt_q  <= 12'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cap.duty   = duty_q;
  assign cap.period = period_q;
  assign cap.vld    = vld_q;
  assign cap.stuck  = stuck_q;
  assign cap.level  = s2_q;

endmodule
